// File: rtl/rising_edge_detector.sv
// Single-cycle rising-edge detector on a synchronous input.
module rising_edge_detector (
   input  logic Clock,
   input  logic Reset,
   input  logic Signal_i,
   output logic Edge_o
);

   logic prev_q;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= Signal_i;
      end
   end

   assign Edge_o = Signal_i & ~prev_q;

endmodule

// File: rtl/strobe_period_meter.sv
// Measures Clock cycles between strobe rising edges and flags
// a strobe that has gone silent for longer than TIMEOUT_NS.
module strobe_period_meter #(
   parameter  int unsigned     CLOCK_HZ   = 10_000_000,
   parameter  int unsigned     TIMEOUT_NS = 10_000,
   localparam longint unsigned TIMEOUT_CYCLES =
      64'(CLOCK_HZ) * 64'(TIMEOUT_NS) / 64'd1_000_000_000,
   localparam int              WIDTH = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable_i,
   input  logic             Strobe_i,
   output logic [WIDTH-1:0] Period_o,
   output logic             Valid_o,
   output logic             Timeout_o
);

   if (TIMEOUT_CYCLES <= 1) begin : g_bad_timeout
      $fatal(1, "strobe_period_meter: TIMEOUT_CYCLES must exceed 1");
   end

   localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT_CYCLES);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      TIMEOUT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] per_q, per_d;
   logic             vld_q, vld_d;
   logic             to_q, to_d;
   logic             strobe_edge;

   rising_edge_detector u_edge (
      .Clock    (Clock),
      .Reset    (Reset),
      .Signal_i (Strobe_i),
      .Edge_o   (strobe_edge)
   );

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         per_q   <= '0;
         vld_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         vld_q   <= vld_d;
         to_q    <= to_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      vld_d   = 1'b0;
      to_d    = to_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (Enable_i && strobe_edge) begin
               state_d = ARMED;
               cnt_d   = ONE;
            end
         end
         ARMED: begin
            // Edge beats the limit so an interval of exactly LIMIT is valid
            if (!Enable_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (strobe_edge) begin
               per_d = cnt_q;
               vld_d = 1'b1;
               cnt_d = ONE;
            end else if (cnt_q == LIMIT) begin
               state_d = TIMEOUT;
               to_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         TIMEOUT: begin
            if (!Enable_i) begin
               state_d = IDLE;
               cnt_d   = '0;
               to_d    = 1'b0;
            end else if (strobe_edge) begin
               state_d = ARMED;
               cnt_d   = ONE;
               to_d    = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            to_d    = 1'b0;
         end
      endcase
   end

   assign Period_o  = per_q;
   assign Valid_o   = vld_q;
   assign Timeout_o = to_q;

endmodule

// File: tb/tb_strobe_period_meter.sv
// Scoreboard bench: expected periods are queued when edges are
// driven and popped whenever the meter raises Valid_o.
module tb_strobe_period_meter;

   localparam int WIDTH = 7;

   logic             Clock = 1'b0;
   logic             Reset = 1'b0;
   logic             Enable_i = 1'b0;
   logic             Strobe_i = 1'b0;
   logic [WIDTH-1:0] Period_o;
   logic             Valid_o;
   logic             Timeout_o;

   int n_chk  = 0;
   int n_pass = 0;
   int exp_q[$];
   bit to_allowed = 1'b0;

   strobe_period_meter #(
      .CLOCK_HZ   (10_000_000),
      .TIMEOUT_NS (10_000)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Enable_i  (Enable_i),
      .Strobe_i  (Strobe_i),
      .Period_o  (Period_o),
      .Valid_o   (Valid_o),
      .Timeout_o (Timeout_o)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic pulses(input int n, input int per,
                         input int hi, input int first);
      for (int i = 0; i < n; i++) begin
         if (i >= first) exp_q.push_back(per);
         Strobe_i = 1'b1;
         step(hi);
         Strobe_i = 1'b0;
         step(per - hi);
      end
   endtask

   task automatic rearm();
      Enable_i = 1'b0;
      step(3);
      Enable_i = 1'b1;
   endtask

   task automatic drain(input string tag);
      step(2);
      chk(tag, exp_q.size(), 0);
   endtask

   // Output monitor, sampling mid-cycle
   always @(negedge Clock) begin
      if (Reset) begin
         if (Valid_o) begin
            if (exp_q.size() == 0) begin
               chk("valid_unexpected", 1, 0);
            end else begin
               chk("period", 32'(Period_o), exp_q.pop_front());
            end
         end
         if (!to_allowed) chk("timeout_quiet", 32'(Timeout_o), 0);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(2);
      chk("rst_period", 32'(Period_o), 0);
      chk("rst_valid", 32'(Valid_o), 0);
      chk("rst_timeout", 32'(Timeout_o), 0);
      Reset = 1'b1;
      Enable_i = 1'b1;
      step(2);

      // 1: 10-cycle period, 1-cycle strobes
      pulses(6, 10, 1, 1);
      drain("t1_drain");

      // 2: wide strobes, 20-cycle period
      rearm();
      pulses(4, 20, 5, 1);
      drain("t2_drain");

      // 3: silence after one edge, then recovery
      rearm();
      to_allowed = 1'b1;
      Strobe_i = 1'b1;
      step(1);
      Strobe_i = 1'b0;
      step(99);
      chk("t3_to_early", 32'(Timeout_o), 0);
      step(1);
      chk("t3_to_rise", 32'(Timeout_o), 1);
      chk("t3_period_hold", 32'(Period_o), 20);
      step(5);
      Strobe_i = 1'b1;
      step(1);
      Strobe_i = 1'b0;
      chk("t3_to_clear", 32'(Timeout_o), 0);
      to_allowed = 1'b0;
      step(9);
      pulses(1, 10, 1, 0);
      drain("t3_drain");

      // 4: exactly at the limit, then one past it
      rearm();
      pulses(3, 100, 1, 1);
      rearm();
      to_allowed = 1'b1;
      Strobe_i = 1'b1;
      step(1);
      Strobe_i = 1'b0;
      step(100);
      chk("t4_to_rise", 32'(Timeout_o), 1);
      Strobe_i = 1'b1;
      step(1);
      Strobe_i = 1'b0;
      chk("t4_to_clear", 32'(Timeout_o), 0);
      to_allowed = 1'b0;
      step(5);
      drain("t4_drain");

      // 5: enable dropped mid-interval
      rearm();
      pulses(3, 10, 1, 1);
      exp_q.push_back(10);
      Strobe_i = 1'b1;
      step(1);
      Strobe_i = 1'b0;
      step(3);
      Enable_i = 1'b0;
      step(2);
      chk("t5_period_hold", 32'(Period_o), 10);
      step(1);
      Enable_i = 1'b1;
      step(3);
      Strobe_i = 1'b1;
      step(1);
      Strobe_i = 1'b0;
      step(9);
      pulses(2, 10, 1, 0);
      step(4);
      chk("t5_q_empty", exp_q.size(), 0);

      // 6: asynchronous reset while armed
      #2;
      Reset = 1'b0;
      #1;
      chk("t6_period", 32'(Period_o), 0);
      chk("t6_valid", 32'(Valid_o), 0);
      chk("t6_timeout", 32'(Timeout_o), 0);
      Strobe_i = 1'b1;
      @(negedge Clock);
      Reset = 1'b1;
      step(3);
      Strobe_i = 1'b0;
      step(7);
      pulses(1, 10, 1, 0);
      drain("t6_drain");
      chk("t6_period_final", 32'(Period_o), 10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/strobe_period_meter.md
Name: strobe_period_meter

Overview:
Receive-side companion to the periodic strobe source. It measures the number of Clock cycles between consecutive rising edges of an incoming strobe and publishes each measurement with a one-cycle valid pulse. It raises a timeout flag when no edge arrives within TIMEOUT_NS. Used to check tick rates and to detect a dead or stalled strobe source.

Parameters:
CLOCK_HZ, 10_000_000, Clock frequency in Hz.
TIMEOUT_NS, 10_000, maximum accepted edge-to-edge interval in ns.
TIMEOUT_CYCLES (localparam), CLOCK_HZ*TIMEOUT_NS/1_000_000_000 (integer math), timeout in cycles. Elaboration $fatal if <= 1.
WIDTH (localparam), $clog2(TIMEOUT_CYCLES+1), width of the counter and of Period_o.

Ports:
Clock  input  1  system clock, all logic on posedge.
Reset  input  1  asynchronous, active-low reset.
Enable_i  input  1  measurement enable; low forces IDLE.
Strobe_i  input  1  synchronous strobe input; a rising edge is the measured event.
Period_o  output  WIDTH  last valid edge-to-edge interval in cycles.
Valid_o  output  1  one-cycle pulse when Period_o is updated.
Timeout_o  output  1  level; high while in TIMEOUT.

Behaviour:
- Reset (Reset=0, async):
  - state=IDLE, Counter=0, StrobePrev=0.
  - Period_o=0, Valid_o=0, Timeout_o=0.
- Edge detect: Edge = Strobe_i & ~StrobePrev. StrobePrev<=Strobe_i every cycle, regardless of Enable_i.
  - Strobe_i already high on the first cycle after reset release counts as an edge.
  - A strobe held high for several cycles counts as one edge.
- Valid_o defaults to 0 every cycle; it is high only in the cycle after a measured edge.
- States:
  - IDLE: Counter held 0. If Enable_i & Edge -> ARMED, Counter<=1.
  - ARMED, evaluated in priority order:
    - Enable_i=0 -> IDLE.
    - Else if Edge: Period_o<=Counter, Valid_o<=1, Counter<=1, stay ARMED.
    - Else if Counter==TIMEOUT_CYCLES -> TIMEOUT, Timeout_o<=1.
    - Else Counter<=Counter+1.
  - TIMEOUT:
    - Enable_i=0 -> IDLE, Timeout_o<=0.
    - Else if Edge -> ARMED, Counter<=1, Timeout_o<=0. No Valid_o; the interval is discarded.
    - Else Counter holds.
- Latency and counting rules:
  - For edges in cycles t0 and t1, Period_o = t1-t0.
  - Period_o and Valid_o are visible at t1+1.
- Boundary: an edge in the same cycle that Counter==TIMEOUT_CYCLES wins, giving Period_o=TIMEOUT_CYCLES with Valid_o and no timeout.
  - Counter never exceeds TIMEOUT_CYCLES, so no wrap-around is possible.
- Timeout timing: Timeout_o rises at t0+TIMEOUT_CYCLES+1 after the last edge at t0.
- Enable_i low:
  - Period_o retains its last value; Valid_o=0; Timeout_o cleared next cycle.
  - After re-enable, two edges are needed before the next Valid_o.
- Enable_i low in the same cycle as an edge: disable wins and no measurement is taken.
- Reset mid-operation clears everything immediately; there is no pending Valid_o after release.

Decomposition:
- No shared package. State encoding (IDLE, ARMED, TIMEOUT) is a localparam set in the module.
- TIMEOUT_CYCLES and WIDTH are localparams.
- One natural sub-module: rising_edge_detector (Clock, Reset, Signal_i, Edge_o), reusable elsewhere in the codebase.

Test Plan:
1. CLOCK_HZ=10_000_000, TIMEOUT_NS=10_000 (100 cycles); 1-cycle strobes every 10 cycles, Enable_i=1 -> no Valid_o after the first edge, then Valid_o every 10 cycles with Period_o=10; Timeout_o stays 0.
2. Strobe held high 5 cycles, edges 20 cycles apart -> Period_o=20, exactly one Valid_o per edge pair.
3. Single edge at t0, then silence -> Timeout_o=1 at t0+101, Period_o unchanged. Next edge -> Timeout_o=0 one cycle later with no Valid_o; an edge 10 cycles after that -> Period_o=10.
4. Edges exactly 100 cycles apart -> Valid_o with Period_o=100, Timeout_o never asserts. Edges 101 cycles apart -> Timeout_o asserts, no Valid_o for that interval.
5. Periodic strobes at 10 cycles; drop Enable_i for 3 cycles mid-interval -> no Valid_o, Period_o holds 10. After re-enable, the first Valid_o comes on the second edge.
6. Assert Reset asynchronously (mid-clock) while ARMED with Period_o=10 -> Period_o, Valid_o and Timeout_o go to 0 immediately. Strobe_i=1 at release with Enable_i=1 -> that first cycle counts as the first edge.
